// File: rtl/squeeze_weight_streamer_if.sv
// Beat stream from the squeeze weight streamer to the MAC array.
// Carries FILT x CH weights, FILT biases and the group position of each beat.
interface squeeze_weight_streamer_if #(
    parameter int DW   = 16,
    parameter int CH   = 16,
    parameter int FILT = 8
);
    logic                   out_valid;
    logic                   out_ready;
    logic [FILT*CH*DW-1:0]  out_w;
    logic [FILT*DW-1:0]     out_bias;
    logic [7:0]             out_fg;
    logic [7:0]             out_cg;
    logic                   out_last_cg;
    logic                   out_last;

    modport master (
        output out_valid, out_w, out_bias, out_fg, out_cg, out_last_cg, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_w, out_bias, out_fg, out_cg, out_last_cg, out_last,
        output out_ready
    );
endinterface

// File: rtl/squeeze_weight_streamer.sv
// Banked weight/bias store for the squeeze stage; streams one layer as
// FILT x CH weight beats (fg outer, cg inner) over a valid/ready interface.
module squeeze_weight_streamer #(
    parameter int DW     = 16,
    parameter int CH     = 16,
    parameter int FILT   = 8,
    parameter int WDEPTH = 4096,
    parameter int BDEPTH = 64,
    parameter int WAW    = $clog2(WDEPTH),
    parameter int BAW    = $clog2(BDEPTH),
    parameter int FBW    = (FILT > 1) ? $clog2(FILT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_en,
    input  logic             ld_sel,
    input  logic [FBW-1:0]   ld_bank,
    input  logic [WAW-1:0]   ld_addr,
    input  logic [CH*DW-1:0] ld_data,
    input  logic             start,
    input  logic [9:0]       cfg_inch,
    input  logic [7:0]       cfg_nfilt,
    input  logic [WAW-1:0]   cfg_wbase,
    input  logic [BAW-1:0]   cfg_bbase,
    squeeze_weight_streamer_if.master sw,
    output logic             busy,
    output logic             done,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state, state_nx;
    logic            cfg_ok, go, bad, rd_en, wr_en, last_rd, last_cg, accept;
    logic [7:0]      fg, cg, ncg, nfg;
    logic [WAW-1:0]  waddr;
    logic [BAW-1:0]  baddr;

    logic [FILT-1:0][CH*DW-1:0] wq;
    logic [FILT-1:0][DW-1:0]    bq;

    assign cfg_ok  = (cfg_inch != '0) && ((int'(cfg_inch) % CH) == 0) &&
                     (cfg_nfilt != '0) && ((int'(cfg_nfilt) % FILT) == 0);
    assign last_cg = (cg == ncg - 8'd1);
    assign last_rd = last_cg && (fg == nfg - 8'd1);
    assign accept  = sw.out_valid && sw.out_ready;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        go       = 1'b0;
        bad      = 1'b0;
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        case (state)
            IDLE: begin
                wr_en = ld_en && !rst;
                if (start) begin
                    if (cfg_ok) begin
                        go       = 1'b1;
                        state_nx = RUN;
                    end else begin
                        bad = 1'b1;
                    end
                end
            end
            RUN: begin
                // RAM output regs are the output stage: only refill when empty or draining
                rd_en = !sw.out_valid || sw.out_ready;
                if (rd_en && last_rd) state_nx = DRAIN;
            end
            DRAIN: if (accept) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Weight row is wbase + fg*NCG + cg, which is simply wbase + beat index.
    always_ff @(posedge clk) begin
        if (rst) begin
            fg             <= '0;
            cg             <= '0;
            ncg            <= '0;
            nfg            <= '0;
            waddr          <= '0;
            baddr          <= '0;
            sw.out_valid   <= 1'b0;
            sw.out_fg      <= '0;
            sw.out_cg      <= '0;
            sw.out_last_cg <= 1'b0;
            sw.out_last    <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= bad;
            if (go) begin
                ncg   <= 8'(int'(cfg_inch) / CH);
                nfg   <= 8'(int'(cfg_nfilt) / FILT);
                fg    <= '0;
                cg    <= '0;
                waddr <= cfg_wbase;
                baddr <= cfg_bbase;
            end
            if (rd_en) begin
                sw.out_valid   <= 1'b1;
                sw.out_fg      <= fg;
                sw.out_cg      <= cg;
                sw.out_last_cg <= last_cg;
                sw.out_last    <= last_rd;
                waddr          <= waddr + WAW'(1);
                if (last_cg) begin
                    cg    <= '0;
                    fg    <= fg + 8'd1;
                    baddr <= baddr + BAW'(1);
                end else begin
                    cg <= cg + 8'd1;
                end
            end else if (state == DRAIN && accept) begin
                sw.out_valid <= 1'b0;
                done         <= 1'b1;
            end
        end
    end

    for (genvar b = 0; b < FILT; b++) begin : g_bank
        logic [CH*DW-1:0] wmem [WDEPTH];
        logic [DW-1:0]    bmem [BDEPTH];
        logic [CH*DW-1:0] wrd;
        logic [DW-1:0]    brd;

        always_ff @(posedge clk) begin
            if (wr_en && ld_bank == FBW'(b)) begin
                if (ld_sel) bmem[ld_addr[BAW-1:0]] <= ld_data[DW-1:0];
                else        wmem[ld_addr]          <= ld_data;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                wrd <= '0;
                brd <= '0;
            end else if (rd_en) begin
                wrd <= wmem[waddr];
                brd <= bmem[baddr];
            end
        end

        assign wq[b] = wrd;
        assign bq[b] = brd;
    end

    assign sw.out_w    = wq;
    assign sw.out_bias = bq;
endmodule

// File: tb/tb_squeeze_weight_streamer.sv
// Randomised bench for squeeze_weight_streamer against an array model of the
// banked memory and the fg/cg beat order computed directly from layer geometry.
module tb_squeeze_weight_streamer;
    localparam int DW = 16, CH = 16, FILT = 8, WDEPTH = 4096, BDEPTH = 64;
    localparam int WAW = 12, BAW = 6, FBW = 3;
    localparam int RW = CH * DW;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ld_en = 1'b0, ld_sel = 1'b0;
    logic [FBW-1:0]   ld_bank = '0;
    logic [WAW-1:0]   ld_addr = '0;
    logic [RW-1:0]    ld_data = '0;
    logic             start = 1'b0;
    logic [9:0]       cfg_inch = '0;
    logic [7:0]       cfg_nfilt = '0;
    logic [WAW-1:0]   cfg_wbase = '0;
    logic [BAW-1:0]   cfg_bbase = '0;
    logic             busy, done, err;

    always #5 clk = ~clk;

    squeeze_weight_streamer_if #(.DW(DW), .CH(CH), .FILT(FILT)) sw ();

    squeeze_weight_streamer #(.DW(DW), .CH(CH), .FILT(FILT), .WDEPTH(WDEPTH), .BDEPTH(BDEPTH)) dut (
        .clk(clk), .rst(rst), .ld_en(ld_en), .ld_sel(ld_sel), .ld_bank(ld_bank),
        .ld_addr(ld_addr), .ld_data(ld_data), .start(start), .cfg_inch(cfg_inch),
        .cfg_nfilt(cfg_nfilt), .cfg_wbase(cfg_wbase), .cfg_bbase(cfg_bbase),
        .sw(sw), .busy(busy), .done(done), .err(err)
    );

    logic [RW-1:0] wm [FILT][WDEPTH];
    logic [DW-1:0] bm [FILT][BDEPTH];
    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RW-1:0] rnd_row();
        logic [RW-1:0] r;
        for (int k = 0; k < RW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic ld(input bit sel, input int bank, input int addr, input logic [RW-1:0] data);
        ld_en = 1'b1; ld_sel = sel; ld_bank = FBW'(bank); ld_addr = WAW'(addr); ld_data = data;
        if (sel) bm[bank][addr % BDEPTH] = data[DW-1:0];
        else     wm[bank][addr % WDEPTH] = data;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic load_layer(input int wb, input int bb, input int ncg, input int nfg);
        for (int b = 0; b < FILT; b++) begin
            for (int i = 0; i < ncg * nfg; i++) ld(1'b0, b, (wb + i) % WDEPTH, rnd_row());
            for (int i = 0; i < nfg; i++) ld(1'b1, b, (bb + i) % BDEPTH, rnd_row());
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int f = 0; f < FILT; f++) chk({tag, "_w"}, sw.out_w[f*RW +: RW], '0);
        chk({tag, "_bias"}, RW'(sw.out_bias), '0);
        chk({tag, "_fg"}, RW'(sw.out_fg), '0);
        chk({tag, "_cg"}, RW'(sw.out_cg), '0);
        chk({tag, "_ctl"}, RW'({sw.out_valid, sw.out_last, sw.out_last_cg, busy, done, err}), '0);
    endtask

    task automatic run_layer(input int inch, input int nfilt, input int wb, input int bb,
                             input int rdy_pct, input int stall_beat, input bit poke, input bit ld_first);
        int ncg = inch / CH, nfg = nfilt / FILT;
        int total = ncg * nfg, acc = 0, cyc = 0, stalls = 0, fgi, cgi, row;
        bit fin = 0, prev_stall = 0, first = 1, fin_now, rdy;
        logic [FILT*RW-1:0] pw;
        logic [FILT*DW-1:0] pb, eb;
        logic [7:0] pfg, pcg;
        logic [2:0] pctl;
        cfg_inch = 10'(inch); cfg_nfilt = 8'(nfilt); cfg_wbase = WAW'(wb); cfg_bbase = BAW'(bb);
        start = 1'b1;
        if (ld_first) begin
            ld_data = rnd_row(); ld_en = 1'b1; ld_sel = 1'b0; ld_bank = 3'd3; ld_addr = WAW'(wb);
            wm[3][wb % WDEPTH] = ld_data;
        end
        tick();
        start = 1'b0; ld_en = 1'b0;
        chk("busy_t0", RW'(busy), RW'(1));
        chk("valid_t0", RW'(sw.out_valid), '0);
        while (!fin && cyc < 2000) begin
            cyc++;
            fin_now = 0;
            if (sw.out_valid && acc == stall_beat && stalls < 5) begin
                rdy = 0; stalls++;
            end else begin
                rdy = ($urandom_range(99) < rdy_pct);
            end
            sw.out_ready = rdy;
            if (poke && cyc == 2) begin
                start = 1'b1; cfg_inch = 10'(CH); cfg_nfilt = 8'(FILT);
                row = (wb + total - 1) % WDEPTH;
                ld_en = 1'b1; ld_sel = 1'b0; ld_bank = 3'd0; ld_addr = WAW'(row); ld_data = ~wm[0][row];
            end
            if (sw.out_valid && rdy) begin
                fgi = acc / ncg; cgi = acc % ncg;
                for (int f = 0; f < FILT; f++) begin
                    chk("beat_w", sw.out_w[f*RW +: RW], wm[f][(wb + fgi * ncg + cgi) % WDEPTH]);
                    eb[f*DW +: DW] = bm[f][(bb + fgi) % BDEPTH];
                end
                chk("beat_bias", RW'(sw.out_bias), RW'(eb));
                chk("beat_fg", RW'(sw.out_fg), RW'(fgi));
                chk("beat_cg", RW'(sw.out_cg), RW'(cgi));
                chk("beat_last_cg", RW'(sw.out_last_cg), RW'(cgi == ncg - 1));
                chk("beat_last", RW'(sw.out_last), RW'(acc == total - 1));
                acc++;
                fin_now = (acc == total);
            end else if (sw.out_valid) begin
                prev_stall = 1;
                pw = sw.out_w; pb = sw.out_bias; pfg = sw.out_fg; pcg = sw.out_cg;
                pctl = {sw.out_valid, sw.out_last, sw.out_last_cg};
            end
            tick();
            start = 1'b0; ld_en = 1'b0;
            if (first) chk("latency_t1", RW'(sw.out_valid), RW'(1));
            first = 0;
            if (poke && cyc == 2) chk("err_while_busy", RW'(err), '0);
            if (prev_stall) begin
                for (int f = 0; f < FILT; f++) chk("stall_w", sw.out_w[f*RW +: RW], pw[f*RW +: RW]);
                chk("stall_bias", RW'(sw.out_bias), RW'(pb));
                chk("stall_pos", RW'({sw.out_fg, sw.out_cg}), RW'({pfg, pcg}));
                chk("stall_ctl", RW'({sw.out_valid, sw.out_last, sw.out_last_cg}), RW'(pctl));
                prev_stall = 0;
            end
            if (fin_now) begin
                chk("done_pulse", RW'(done), RW'(1));
                chk("end_valid", RW'(sw.out_valid), '0);
                chk("end_busy", RW'(busy), '0);
                fin = 1;
            end else begin
                chk("done_early", RW'(done), '0);
            end
        end
        chk("beat_count", RW'(acc), RW'(total));
        sw.out_ready = 1'b0;
        tick();
        chk("done_once", RW'(done), '0);
    endtask

    task automatic illegal(input int inch, input int nfilt);
        cfg_inch = 10'(inch); cfg_nfilt = 8'(nfilt); start = 1'b1;
        tick();
        start = 1'b0;
        chk("ill_err", RW'(err), RW'(1));
        chk("ill_busy", RW'(busy), '0);
        tick();
        chk("ill_err_clr", RW'(err), '0);
        chk("ill_state", RW'({busy, sw.out_valid}), '0);
        tick();
        chk("ill_valid", RW'(sw.out_valid), '0);
    endtask

    task automatic reset_mid();
        int acc = 0, cyc = 0;
        cfg_inch = 10'd32; cfg_nfilt = 8'd16; cfg_wbase = WAW'(10); cfg_bbase = '0;
        start = 1'b1; sw.out_ready = 1'b1;
        tick();
        start = 1'b0;
        while (acc < 2 && cyc < 20) begin
            cyc++;
            if (sw.out_valid) acc++;
            tick();
        end
        chk("rm_beats", RW'(acc), RW'(2));
        rst = 1'b1;
        tick();
        chk_zero("rm");
        rst = 1'b0; sw.out_ready = 1'b0;
        repeat (3) begin
            tick();
            chk("rm_quiet", RW'({done, sw.out_valid, busy}), '0);
        end
        run_layer(32, 16, 10, 0, 100, -1, 0, 0);
    endtask

    initial begin
        int nc, nf, wb, bb;
        logic [RW-1:0] r;
        sw.out_ready = 1'b0;
        tick(); tick();
        chk_zero("reset");
        rst = 1'b0;

        for (int f = 0; f < FILT; f++) begin
            for (int c = 0; c < CH; c++) r[c*DW +: DW] = DW'(f * 256 + c);
            ld(1'b0, f, 0, r);
            ld(1'b1, f, 0, RW'(16'h100 + f));
        end
        run_layer(16, 8, 0, 0, 100, -1, 0, 0);

        load_layer(10, 0, 2, 2);
        run_layer(32, 16, 10, 0, 100, -1, 0, 0);
        run_layer(32, 16, 10, 0, 100, 1, 0, 0);
        run_layer(32, 16, 10, 0, 100, -1, 1, 0);
        run_layer(32, 16, 10, 0, 100, -1, 0, 1);

        illegal(24, 16);
        illegal(0, 8);
        illegal(16, 12);
        illegal(16, 0);

        reset_mid();

        load_layer(4094, 63, 2, 2);
        run_layer(32, 16, 4094, 63, 70, -1, 0, 0);

        repeat (6) begin
            nc = $urandom_range(1, 4); nf = $urandom_range(1, 4);
            wb = $urandom_range(0, WDEPTH - 1); bb = $urandom_range(0, BDEPTH - 1);
            load_layer(wb, bb, nc, nf);
            run_layer(nc * CH, nf * FILT, wb, bb, 60, $urandom_range(0, nc * nf - 1), 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
